i2c_target: RTL and testbench

- I2C responder (slave) for the fabric side of the same bus the i2c_simple initiator drives.
- Watches the bus through the IOBUF-split scl/sda signals and answers one 7-bit address.
- Supports pointer-based byte writes and reads with auto-increment, mapped onto a simple fabric register port.
- Used as an on-chip loopback target for bring-up and as a reusable peripheral-emulation block.

---
 rtl/i2c_target.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target (responder) with pointer-based register access.
// Answers one 7-bit address and maps byte writes/reads onto a fabric
// register port. The pointer auto-increments after every data byte.
// Optional glitch filter on the synchronised lines is enabled by the
// macro I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target #(
  parameter logic [6:0]  I2C_ADDR    = 7'h42,
  parameter int unsigned PTR_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  input  logic             scl_i,
  output logic             scl_o,
  output logic             scl_t,
  input  logic             sda_i,
  output logic             sda_o,
  output logic             sda_t,
  output logic             wr_valid,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             rd_req,
  output logic [PTR_W-1:0] rd_addr,
  input  logic [7:0]       rd_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WDATA,
    ST_RDATA,
    ST_IGNORE
  } state_e;

  // The block never drives SCL and only ever pulls SDA low.
  assign scl_o = 1'b0;
  assign scl_t = 1'b1;
  assign sda_o = 1'b0;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_s, sda_s;
  logic                   scl_f, sda_f;

  // Synchronisers; reset to the idle-high bus level.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] scl_cnt_q, sda_cnt_q;
  logic              scl_flt_q, sda_flt_q;

  // Filtered line follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
    end else begin
      if (scl_s == scl_flt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        scl_flt_q <= scl_s;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + FCNT_W'(1);
      end
      if (sda_s == sda_flt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
        sda_flt_q <= sda_s;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + FCNT_W'(1);
      end
    end
  end

  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  logic unused_filter_len;

  assign scl_f             = scl_s;
  assign sda_f             = sda_s;
  assign unused_filter_len = (FILTER_LEN == 32'd0);
`endif

  logic scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Previous filtered levels for edge and bus-condition detection.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             ninth_q, ninth_d;       // inside the 9th (ACK) clock
  logic             ack_rise_q, ack_rise_d; // 9th SCL rise already seen
  logic             rw_q, rw_d;
  logic             rd_lat_q, rd_lat_d;
  logic             sda_t_q, sda_t_d;
  logic             busy_q, busy_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             rd_req_q, rd_req_d;
  logic [PTR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]       rx_byte;

  assign rx_byte = {shift_q, sda_f};

  // State and datapath registers.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      ninth_q    <= 1'b0;
      ack_rise_q <= 1'b0;
      rw_q       <= 1'b0;
      rd_lat_q   <= 1'b0;
      sda_t_q    <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      ninth_q    <= ninth_d;
      ack_rise_q <= ack_rise_d;
      rw_q       <= rw_d;
      rd_lat_q   <= rd_lat_d;
      sda_t_q    <= sda_t_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Next-state logic: bus conditions first, then per-state bit handling.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    ninth_d    = ninth_q;
    ack_rise_d = ack_rise_q;
    rw_d       = rw_q;
    sda_t_d    = sda_t_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_lat_d   = rd_req_q;

    // Read data is captured one cycle after the request.
    if (rd_lat_q) begin
      tx_d = rd_data;
    end

    if (start_det || stop_det) begin
      state_d    = start_det ? ST_ADDR : ST_IDLE;
      bit_cnt_d  = '0;
      ninth_d    = 1'b0;
      ack_rise_d = 1'b0;
      sda_t_d    = 1'b1;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (!ninth_q) begin
            if (scl_rise) begin
              shift_d   = rx_byte[6:0];
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ninth_d = 1'b1;
                if (state_q == ST_ADDR) begin
                  if (rx_byte[7:1] == I2C_ADDR) begin
                    busy_d = 1'b1;
                    rw_d   = rx_byte[0];
                    if (rx_byte[0]) begin
                      rd_req_d  = 1'b1;
                      rd_addr_d = ptr_q;
                    end
                  end else begin
                    state_d = ST_IGNORE;
                    ninth_d = 1'b0;
                  end
                end else if (state_q == ST_PTR) begin
                  ptr_d = PTR_W'(rx_byte);
                end else begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = ptr_q;
                  wr_data_d  = rx_byte;
                  ptr_d      = ptr_q + PTR_W'(1);
                end
              end
            end
          end else if (scl_rise) begin
            ack_rise_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_t_d = 1'b0;
            end else begin
              ninth_d    = 1'b0;
              ack_rise_d = 1'b0;
              sda_t_d    = 1'b1;
              if (state_q == ST_ADDR) begin
                if (rw_q) begin
                  state_d = ST_RDATA;
                  sda_t_d = tx_q[7];
                end else begin
                  state_d = ST_PTR;
                end
              end else if (state_q == ST_PTR) begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (!ninth_q) begin
            if (scl_rise) begin
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                ninth_d = 1'b1;
              end
            end else if (scl_fall) begin
              sda_t_d = tx_q[7];
            end
          end else if (scl_rise) begin
            ack_rise_d = 1'b1;
            ptr_d      = ptr_q + PTR_W'(1);
            if (!sda_f) begin
              rd_req_d  = 1'b1;
              rd_addr_d = ptr_q + PTR_W'(1);
            end else begin
              state_d    = ST_IGNORE;
              ninth_d    = 1'b0;
              ack_rise_d = 1'b0;
            end
          end else if (scl_fall) begin
            if (!ack_rise_q) begin
              sda_t_d = 1'b1;
            end else begin
              ninth_d    = 1'b0;
              ack_rise_d = 1'b0;
              sda_t_d    = tx_q[7];
            end
          end
        end

        ST_IDLE, ST_IGNORE: begin
          state_d = state_q;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign sda_t    = sda_t_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: table of transactions, hand-written reset and
// glitch sequences, then randomised transactions against a byte-level model.
module tb_i2c_target;

  localparam int unsigned Q     = 8;
  localparam logic [6:0]  TADDR = 7'h42;

  typedef struct {
    logic [6:0]  addr;
    bit          rd;
    bit          wp;
    logic [7:0]  ptr;
    int          n;
    logic [31:0] data;
    bit          exp_ack;
    logic [7:0]  exp_first;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       wr_valid, rd_req, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_bus;

  assign sda_bus = sda_m & sda_t;

  i2c_target dut (
    .axi_aclk  (clk),
    .axi_areset(rst),
    .scl_i     (scl_m),
    .scl_o     (scl_o),
    .scl_t     (scl_t),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  mptr  = 8'h00;
  logic [15:0] wr_seen[$];
  logic [7:0]  rd_seen[$];
  int unsigned low_cnt = 0;
  int unsigned stable_viol = 0;
  logic        scl_prev = 1'b1;
  logic        sda_t_prev = 1'b1;

  // Register-port model (rd_data = addr^FF one cycle after rd_req) and bus monitor.
  always @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else if (rd_req) rd_data <= rd_addr ^ 8'hFF;
    if (wr_valid) wr_seen.push_back({wr_addr, wr_data});
    if (rd_req) rd_seen.push_back(rd_addr);
    if (!sda_t) low_cnt <= low_cnt + 1;
    if (!rst && scl_m && scl_prev && (sda_t !== sda_t_prev)) stable_viol <= stable_viol + 1;
    scl_prev   <= scl_m;
    sda_t_prev <= sda_t;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic hq(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hq(Q);
    scl_m = 1'b1; hq(Q);
    sda_m = 1'b0; hq(Q);
    scl_m = 1'b0; hq(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hq(Q);
    scl_m = 1'b1; hq(Q);
    sda_m = 1'b1; hq(Q);
  endtask

  // Master writes a byte; optional 2-cycle SDA low glitch during bit 4 high phase.
  task automatic send_byte(input logic [7:0] b, input bit glitch, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hq(Q);
      scl_m = 1'b1;
      if (glitch && i == 4) begin
        hq(Q - 2); sda_m = 1'b0; hq(2); sda_m = 1'b1; hq(Q);
      end else begin
        hq(2 * Q);
      end
      scl_m = 1'b0; hq(Q);
    end
    sda_m = 1'b1; hq(Q);
    scl_m = 1'b1; hq(Q);
    ack = !sda_bus; hq(Q);
    scl_m = 1'b0; hq(Q);
  endtask

  // Master reads a byte and answers ACK (nack=0) or NACK (nack=1).
  task automatic recv_byte(input bit nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      hq(Q); scl_m = 1'b1;
      hq(Q); b[i] = sda_bus;
      hq(Q); scl_m = 1'b0;
    end
    hq(Q); sda_m = nack;
    hq(Q); scl_m = 1'b1;
    hq(2 * Q); scl_m = 1'b0;
    hq(Q); sda_m = 1'b1;
  endtask

  // One full transaction, checked against the byte-level model.
  task automatic run_txn(input vec_t t, output bit ack0, output logic [7:0] first);
    bit          match, ack;
    logic [7:0]  b;
    int          wbase, rbase;
    int unsigned lbase;
    logic [7:0]  exp_wa[$], exp_wd[$], exp_ra[$];
    match = (t.addr == TADDR);
    wbase = wr_seen.size();
    rbase = rd_seen.size();
    lbase = low_cnt;
    first = 8'h00;
    ack0  = 1'b0;
    i2c_start();
    if (t.wp) begin
      send_byte({t.addr, 1'b0}, 1'b0, ack);
      ack0 = ack;
      check("addr_w_ack", 32'(ack), 32'(match));
      check("busy_after_addr_w", 32'(busy), 32'(match));
      send_byte(t.ptr, 1'b0, ack);
      check("ptr_ack", 32'(ack), 32'(match));
      if (match) mptr = t.ptr;
    end
    if (!t.rd) begin
      for (int i = 0; i < t.n; i++) begin
        b = t.data[8*i +: 8];
        send_byte(b, 1'b0, ack);
        check("wdata_ack", 32'(ack), 32'(match));
        if (match) begin
          exp_wa.push_back(mptr);
          exp_wd.push_back(b);
          mptr = mptr + 8'd1;
        end
      end
    end else begin
      if (t.wp) i2c_start();
      send_byte({t.addr, 1'b1}, 1'b0, ack);
      if (!t.wp) ack0 = ack;
      check("addr_r_ack", 32'(ack), 32'(match));
      check("busy_after_addr_r", 32'(busy), 32'(match));
      for (int i = 0; i < t.n; i++) begin
        recv_byte(i == t.n - 1, b);
        if (match) begin
          check("rd_byte", 32'(b), 32'(mptr ^ 8'hFF));
          if (i == 0) first = b;
          exp_ra.push_back(mptr);
          mptr = mptr + 8'd1;
        end
      end
    end
    i2c_stop();
    hq(Q);
    check("busy_after_stop", 32'(busy), 32'd0);
    check("wr_count", 32'(wr_seen.size() - wbase), 32'(exp_wa.size()));
    for (int i = 0; i < exp_wa.size() && wbase + i < wr_seen.size(); i++) begin
      if (i == 0 && !t.rd) first = wr_seen[wbase][15:8];
      check("wr_addr", 32'(wr_seen[wbase + i][15:8]), 32'(exp_wa[i]));
      check("wr_data", 32'(wr_seen[wbase + i][7:0]), 32'(exp_wd[i]));
    end
    check("rd_count", 32'(rd_seen.size() - rbase), 32'(exp_ra.size()));
    for (int i = 0; i < exp_ra.size() && rbase + i < rd_seen.size(); i++) begin
      check("rd_addr", 32'(rd_seen[rbase + i]), 32'(exp_ra[i]));
    end
    if (!match) check("sda_never_driven", low_cnt - lbase, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [7];
    vec_t        rv;
    bit          ack0, ack, exp_g;
    logic [7:0]  first;
    int          wbase;

    vecs[0] = '{7'h42, 1'b0, 1'b1, 8'h10, 2, 32'h0000_3CA5, 1'b1, 8'h10};
    vecs[1] = '{7'h43, 1'b0, 1'b1, 8'h55, 0, 32'h0000_0000, 1'b0, 8'h00};
    vecs[2] = '{7'h42, 1'b0, 1'b1, 8'hFF, 2, 32'h0000_2211, 1'b1, 8'hFF};
    vecs[3] = '{7'h42, 1'b1, 1'b1, 8'h20, 2, 32'h0000_0000, 1'b1, 8'hDF};
    vecs[4] = '{7'h42, 1'b1, 1'b0, 8'h00, 1, 32'h0000_0000, 1'b1, 8'hDD};
    vecs[5] = '{7'h43, 1'b1, 1'b0, 8'h00, 1, 32'h0000_0000, 1'b0, 8'h00};
    vecs[6] = '{7'h42, 1'b0, 1'b1, 8'h7F, 3, 32'h0000_FF80, 1'b1, 8'h7F};

    // Reset values.
    hq(3);
    check("rst_sda_t", 32'(sda_t), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("scl_t_tied", 32'(scl_t), 32'd1);
    check("scl_o_tied", 32'(scl_o), 32'd0);
    check("sda_o_tied", 32'(sda_o), 32'd0);
    rst = 1'b0;
    hq(Q);

    // Directed transaction table.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i], ack0, first);
      check("vec_ack", 32'(ack0), 32'(vecs[i].exp_ack));
      check("vec_first", 32'(first), 32'(vecs[i].exp_first));
    end

    // Reset while the target drives a 0 data bit during a read.
    i2c_start();
    send_byte(8'h84, 1'b0, ack); check("rst_seq_addr_ack", 32'(ack), 32'd1);
    send_byte(8'hFF, 1'b0, ack); check("rst_seq_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    send_byte(8'h85, 1'b0, ack); check("rst_seq_raddr_ack", 32'(ack), 32'd1);
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hq(Q); scl_m = 1'b1; hq(2 * Q); scl_m = 1'b0;
    end
    hq(Q);
    check("rst_seq_driving_zero", 32'(sda_t), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_sda_t", 32'(sda_t), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    hq(4);
    rst = 1'b0;
    mptr = 8'h00;
    hq(Q);
    rv = '{7'h42, 1'b1, 1'b0, 8'h00, 1, 32'h0, 1'b1, 8'hFF};
    run_txn(rv, ack0, first);
    check("post_rst_read_ack", 32'(ack0), 32'd1);
    check("post_rst_read_byte", 32'(first), 32'hFF);
    run_txn(vecs[0], ack0, first);
    check("post_rst_write_first", 32'(first), 32'h10);

    // Short SDA glitch while SCL is high during a data bit.
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_g = 1'b1;
`else
    exp_g = 1'b0;
`endif
    i2c_start();
    send_byte(8'h84, 1'b0, ack); check("glitch_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h40, 1'b0, ack); check("glitch_ptr_ack", 32'(ack), 32'd1);
    mptr  = 8'h40;
    wbase = wr_seen.size();
    send_byte(8'hFF, 1'b1, ack);
    check("glitch_data_ack", 32'(ack), 32'(exp_g));
    i2c_stop();
    hq(Q);
    check("glitch_wr_count", 32'(wr_seen.size() - wbase), 32'(exp_g));
    if (exp_g) mptr = 8'h41;

    // Randomised transactions.
    for (int k = 0; k < 10; k++) begin
      rv.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : TADDR;
      rv.rd   = 1'($urandom_range(0, 1));
      rv.wp   = rv.rd ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.ptr  = 8'($urandom);
      rv.n    = int'($urandom_range(1, 3));
      rv.data = $urandom;
      rv.exp_ack   = 1'b0;
      rv.exp_first = 8'h00;
      run_txn(rv, ack0, first);
      check("rand_ack", 32'(ack0), 32'(rv.addr == TADDR));
    end

    check("sda_stable_while_scl_high", stable_viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
